mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares the single read port of the memory controller between instruction fetch and the data-load path of the Tomasulo core.
- Grants one request per cycle, with data priority bounded by a starvation limit for fetch.
- Tracks outstanding requests in an in-order tag queue and routes each response back to its requester.
- Discards fetch responses that were in flight when a branch flush occurred.
- Sits between fetch/load units and memcontr.

Parameters:
MAX_OUT, 4, maximum outstanding (issued, not yet returned) requests; tag queue depth
STARVE, 3, consecutive fetch losses after which fetch wins over a pending data request
AW, 16, address width
DW, 16, data width

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high; all state cleared on the posedge where reset is sampled high
i_re  in  1  fetch read request, held until granted
i_raddr  in  AW  fetch address
i_gnt  out  1  combinational; fetch request accepted at this edge
d_re  in  1  data read request, held until granted
d_raddr  in  AW  data address
d_gnt  out  1  combinational; data request accepted at this edge
i_flush  in  1  branch flush; kills in-flight fetch responses
mem_re  out  1  registered read strobe to memcontr
mem_raddr  out  AW  registered read address
mem_ready  in  1  memcontr response valid; responses return in issue order
mem_raddr_in  in  AW  response address
mem_data_in  in  DW  response data
i_ready  out  1  registered fetch response valid, 1 cycle
i_raddr_out  out  AW  fetch response address
i_data_out  out  DW  fetch response data
d_ready  out  1  registered data response valid, 1 cycle
d_raddr_out  out  AW  data response address
d_data_out  out  DW  data response data
err  out  1  sticky protocol error

Behaviour:
- Reset values:
  - mem_re, i_ready, d_ready, err = 0.
  - Address/data outputs = 0.
  - Tag queue empty, starve counter = 0.
- Credit: can_issue = (count < MAX_OUT) || mem_ready. A pop in the same cycle frees a slot.
- Grant, evaluated combinationally each cycle:
  - Both gnts are 0 if !can_issue, or if reset is high.
  - i_gnt is additionally 0 while i_flush is high.
  - Priority: d_re wins unless i_re && starve == STARVE, in which case i_gnt = 1 and d_gnt = 0.
  - Otherwise whichever single requester is active wins.
- Starve counter:
  - Increments (saturating at STARVE) when i_re && !i_gnt && d_gnt.
  - Clears on i_gnt, or when i_re is low.
- Issue: at a posedge with a grant:
  - mem_re <= 1 and mem_raddr <= the granted address.
  - A tag {src, killed = 0} is pushed; src is 0 for fetch, 1 for data.
  - Otherwise mem_re <= 0 and mem_raddr holds.
  - mem_re is a 1-cycle pulse per grant; back-to-back grants give consecutive pulses.
- Response: at a posedge with mem_ready, pop the head tag.
  - src = 1 → d_ready <= 1, and d_raddr_out/d_data_out are loaded.
  - src = 0 and not killed → i_ready <= 1, and i_raddr_out/i_data_out are loaded.
  - src = 0 and killed → consumed silently; no ready pulse.
  - Ready outputs drop to 0 the next cycle unless another response pops.
  - Response latency is exactly 1 cycle after mem_ready.
- Flush: at a posedge with i_flush, set killed on every queued fetch tag. This includes a tag popped in the same cycle, which is then dropped.
  - Data tags are unaffected.
  - A fetch request issued on the edge after flush deasserts is live.
- Simultaneous push and pop: count is unchanged; both operations apply.
- mem_ready with an empty queue (and no same-cycle push ahead of it):
  - err <= 1 (sticky until reset).
  - The response is ignored; no ready pulse.
- Reset mid-operation: queue, killed bits and counters are cleared. Responses arriving after reset hit an empty queue and set err; the system resets memcontr together with this block.
- Queue pointers wrap modulo MAX_OUT; count is 0..MAX_OUT.

Test Plan:
- Single fetch: i_re = 1, i_raddr = 0x0010; memcontr responds 2 cycles after mem_re with data 0xBEEF → i_gnt high 1 cycle, mem_re pulse with 0x0010, i_ready pulse 1 cycle after mem_ready with i_data_out = 0xBEEF, d_ready stays 0.
- Contention: i_re and d_re held continuously with new addresses → grant pattern D, D, D, I, D, D, D, I (STARVE = 3); responses routed in issue order to the correct requester.
- Credit limit: memcontr stalls responses, 4 requests granted → 5th request sees gnt = 0 until mem_ready. On the mem_ready cycle, gnt = 1 and the count stays at 4.
- Flush: issue fetch 0x0020, data 0x0100, fetch 0x0022; pulse i_flush before any response → only d_ready fires (for 0x0100); the two fetch responses are dropped. A new fetch to 0x0000 after flush returns i_ready.
- Flush coincident with mem_ready of a fetch tag → that response is dropped; i_gnt is 0 during the flush cycle.
- Protocol error and reset: mem_ready with an empty queue → err = 1 and no ready pulse. Reset high for 1 cycle with 2 tags outstanding → err = 0, count = 0, and all outputs at their reset values.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data-load reads onto the single memcontr read port and
// routes in-order responses back to the requester, dropping flushed fetches.
module mem_arbiter #(
    parameter int MAX_OUT = 4,
    parameter int STARVE  = 3,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic          i_gnt,
    input  logic          d_re,
    input  logic [AW-1:0] d_raddr,
    output logic          d_gnt,
    input  logic          i_flush,
    output logic          mem_re,
    output logic [AW-1:0] mem_raddr,
    input  logic          mem_ready,
    input  logic [AW-1:0] mem_raddr_in,
    input  logic [DW-1:0] mem_data_in,
    output logic          i_ready,
    output logic [AW-1:0] i_raddr_out,
    output logic [DW-1:0] i_data_out,
    output logic          d_ready,
    output logic [AW-1:0] d_raddr_out,
    output logic [DW-1:0] d_data_out,
    output logic          err
);

    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int SW = $clog2(STARVE + 1);

    logic [MAX_OUT-1:0] r_src;
    logic [MAX_OUT-1:0] r_killed;
    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [CW-1:0]      r_count;
    logic [SW-1:0]      r_starve;

    logic               r_memRe;
    logic [AW-1:0]      r_memRaddr;
    logic               r_iReady;
    logic [AW-1:0]      r_iRaddrOut;
    logic [DW-1:0]      r_iDataOut;
    logic               r_dReady;
    logic [AW-1:0]      r_dRaddrOut;
    logic [DW-1:0]      r_dDataOut;
    logic               r_err;

    logic               w_canIssue;
    logic               w_starved;
    logic               w_iGnt;
    logic               w_dGnt;
    logic               w_push;
    logic               w_pop;
    logic               w_headSrc;
    logic               w_headKilled;
    logic               w_iDeliver;
    logic               w_dDeliver;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // A response popping this cycle frees a slot for the request granted now.
    assign w_canIssue = (r_count < CW'(MAX_OUT)) || mem_ready;
    assign w_starved  = (r_starve == SW'(STARVE));

    always_comb begin
        w_iGnt = 1'b0;
        w_dGnt = 1'b0;
        if (!reset && w_canIssue) begin
            if (i_re && !i_flush && (w_starved || !d_re)) begin
                w_iGnt = 1'b1;
            end else if (d_re) begin
                w_dGnt = 1'b1;
            end
        end
    end

    assign w_push       = w_iGnt || w_dGnt;
    assign w_pop        = mem_ready && (r_count != '0);
    assign w_headSrc    = r_src[r_head];
    assign w_headKilled = r_killed[r_head] || i_flush;
    assign w_dDeliver   = w_pop && w_headSrc;
    assign w_iDeliver   = w_pop && !w_headSrc && !w_headKilled;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src       <= '0;
            r_killed    <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_starve    <= '0;
            r_memRe     <= 1'b0;
            r_memRaddr  <= '0;
            r_iReady    <= 1'b0;
            r_iRaddrOut <= '0;
            r_iDataOut  <= '0;
            r_dReady    <= 1'b0;
            r_dRaddrOut <= '0;
            r_dDataOut  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_memRe <= w_push;
            if (w_push) begin
                r_memRaddr <= w_iGnt ? i_raddr : d_raddr;
            end

            // Stale entries get marked too; they are overwritten on push.
            if (i_flush) begin
                r_killed <= r_killed | ~r_src;
            end
            if (w_push) begin
                r_src[r_tail]    <= w_dGnt;
                r_killed[r_tail] <= 1'b0;
                r_tail           <= nextPtr(r_tail);
            end
            if (w_pop) begin
                r_head <= nextPtr(r_head);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);

            r_iReady <= w_iDeliver;
            if (w_iDeliver) begin
                r_iRaddrOut <= mem_raddr_in;
                r_iDataOut  <= mem_data_in;
            end
            r_dReady <= w_dDeliver;
            if (w_dDeliver) begin
                r_dRaddrOut <= mem_raddr_in;
                r_dDataOut  <= mem_data_in;
            end

            if (mem_ready && (r_count == '0)) begin
                r_err <= 1'b1;
            end

            if (!i_re || w_iGnt) begin
                r_starve <= '0;
            end else if (w_dGnt && !w_starved) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    assign i_gnt       = w_iGnt;
    assign d_gnt       = w_dGnt;
    assign mem_re      = r_memRe;
    assign mem_raddr   = r_memRaddr;
    assign i_ready     = r_iReady;
    assign i_raddr_out = r_iRaddrOut;
    assign i_data_out  = r_iDataOut;
    assign d_ready     = r_dReady;
    assign d_raddr_out = r_dRaddrOut;
    assign d_data_out  = r_dDataOut;
    assign err         = r_err;

endmodule
